// File: rtl/approx_mac_pkg.sv
// Shared types and helpers for the sequential approximate MAC.
// Holds the controller state enum and the column-truncation mask builder.
package approx_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } mac_state_t;

    // Widest product the mask helper can describe; slice down at the use site.
    localparam int unsigned MASK_MAX = 128;

    // Ones in columns [approx, prod_width), zeros below approx and above the product.
    function automatic logic [MASK_MAX-1:0] trunc_mask(input int unsigned prod_width,
                                                       input int unsigned approx);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < MASK_MAX; k++) begin
            m[k] = (k >= approx) && (k < prod_width);
        end
        return m;
    endfunction

endpackage

// File: rtl/approx_shift_mul.sv
// Bit-serial shift-add multiplier: one truncated partial product per cycle,
// LSB of b first. done is high during the cycle that adds the final column.
module approx_shift_mul
    import approx_mac_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned APPROX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [MASK_MAX-1:0] FULL_MASK = trunc_mask(PW, APPROX);
    localparam logic [PW-1:0] COL_MASK = FULL_MASK[PW-1:0];

    logic [PW-1:0]    a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             cnt_last;

    assign cnt_last = (cnt == CW'(WIDTH - 1));
    assign done     = busy && cnt_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            product <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            a_sh    <= {{WIDTH{1'b0}}, a};
            b_sh    <= b;
            product <= '0;
        end else if (busy) begin
            // Truncation applies to each shifted partial product, not to the sum.
            if (b_sh[0]) begin
                product <= product + (a_sh & COL_MASK);
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;
            if (cnt_last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/approx_mac_seq.sv
// Sequential approximate MAC: frames of operand beats accumulate onto a bias.
// Optional macro APPROX_MAC_SAT_EN saturates the accumulator on overflow instead of wrapping.
module approx_mac_seq
    import approx_mac_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned APPROX    = 8,
    parameter int unsigned ACC_WIDTH = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_c,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    output logic [1:0]           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds valid and its payload until that edge.

    mac_state_t state, state_nx;

    logic                 mul_start;
    logic                 mul_busy;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   product;

    logic [WIDTH-1:0]     c_q;
    logic                 last_q;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;
    logic                 frame_open;

    logic [ACC_WIDTH-1:0] addend;
    logic [ACC_WIDTH:0]   sum;

    approx_shift_mul #(
        .WIDTH  (WIDTH),
        .APPROX (APPROX)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        mul_start = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    mul_start = 1'b1;
                    state_nx  = MUL;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_nx = ACC;
                end
            end
            ACC: begin
                state_nx = last_q ? OUT : IDLE;
            end
            OUT: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign out_data  = acc;
    assign out_ovf   = ovf;
    assign dbg_state = state;

    // The bias replaces the running sum only on the first beat of a frame.
    always_comb begin
        addend = frame_open ? acc : {{(ACC_WIDTH - WIDTH){1'b0}}, c_q};
        sum    = {1'b0, addend} + {{(ACC_WIDTH + 1 - 2 * WIDTH){1'b0}}, product};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q        <= '0;
            last_q     <= 1'b0;
            acc        <= '0;
            ovf        <= 1'b0;
            frame_open <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c_q    <= in_c;
                        last_q <= in_last;
                    end
                end
                ACC: begin
                    frame_open <= 1'b1;
                    if (sum[ACC_WIDTH]) begin
                        ovf <= 1'b1;
`ifdef APPROX_MAC_SAT_EN
                        acc <= '1;
`else
                        acc <= sum[ACC_WIDTH-1:0];
`endif
                    end else begin
                        acc <= sum[ACC_WIDTH-1:0];
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc        <= '0;
                        ovf        <= 1'b0;
                        frame_open <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mac_seq.sv
// Bench for approx_mac_seq: directed scenarios plus random frames scored
// against an arithmetic model of truncated products and frame accumulation.
module tb_approx_mac_seq;

    localparam int unsigned W      = 16;
    localparam int unsigned AP     = 8;
    localparam int unsigned AW     = 33;
    localparam int          BUDGET = 200;
    localparam logic [63:0] ACC_MAX = (64'd1 << AW) - 64'd1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [W-1:0]  in_c;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          out_ovf;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] exp_q[$];
    logic          ovf_q[$];

    logic [63:0] m_acc;
    logic        m_ovf;
    logic        m_open;

    approx_mac_seq #(
        .WIDTH     (W),
        .APPROX    (AP),
        .ACC_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("ready_valid_excl", {63'd0, in_ready & out_valid}, 64'd0);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] prod_model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        logic [63:0] keep;
        p    = 64'd0;
        keep = ~((64'd1 << AP) - 64'd1);
        for (int i = 0; i < W; i++) begin
            if (b[i]) p = p + (({48'd0, a} << i) & keep);
        end
        return p;
    endfunction

    task automatic model_reset();
        m_acc  = 64'd0;
        m_ovf  = 1'b0;
        m_open = 1'b0;
    endtask

    task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic last);
        logic [63:0] s;
        s = (m_open ? m_acc : {48'd0, c}) + prod_model(a, b);
        m_open = 1'b1;
        if (s > ACC_MAX) begin
            m_ovf = 1'b1;
`ifdef APPROX_MAC_SAT_EN
            m_acc = ACC_MAX;
`else
            m_acc = s & ACC_MAX;
`endif
        end else begin
            m_acc = s;
        end
        if (last) begin
            exp_q.push_back(m_acc[AW-1:0]);
            ovf_q.push_back(m_ovf);
            model_reset();
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic last);
        int n;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_eq("in_ready_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            model_beat(a, b, c, last);
        end
    endtask

    task automatic recv_frame(input int hold, output logic [AW-1:0] got_d, output logic got_o);
        int n;
        logic [AW-1:0] exp_d;
        logic exp_o;
        n = 0;
        while (!out_valid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_eq("out_valid_seen", {63'd0, out_valid}, 64'd1);
        exp_d = '0;
        exp_o = 1'b0;
        if (exp_q.size() > 0) begin
            exp_d = exp_q.pop_front();
            exp_o = ovf_q.pop_front();
        end else begin
            check_eq("sb_underflow", 64'd1, 64'd0);
        end
        for (int h = 0; h < hold; h++) begin
            check_eq("hold_data", {31'd0, out_data}, {31'd0, exp_d});
            check_eq("hold_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check_eq("out_data", {31'd0, out_data}, {31'd0, exp_d});
        check_eq("out_ovf", {63'd0, out_ovf}, {63'd0, exp_o});
        got_d = out_data;
        got_o = out_ovf;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("post_out_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("post_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] d;
        logic o;
        int n;
        logic [W-1:0] ra, rb, rc;
        int nb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_out_data", {31'd0, out_data}, 64'd0);
        check_eq("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full truncation and output latency
        send_beat(16'd3, 16'd5, 16'd0, 1'b1);
        n = 0;
        while (!out_valid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_eq("trunc_latency", n, 18);
        recv_frame(0, d, o);
        check_eq("trunc_data", {31'd0, d}, 64'd0);
        check_eq("trunc_ovf", {63'd0, o}, 64'd0);

        // Exact partial product
        send_beat(16'h0100, 16'h0100, 16'd7, 1'b1);
        recv_frame(1, d, o);
        check_eq("exact_pp", {31'd0, d}, 64'h10007);

        // Maximum operands
        send_beat(16'hFFFF, 16'hFFFF, 16'd0, 1'b1);
        recv_frame(0, d, o);
        check_eq("max_ops", {31'd0, d}, 64'hFFFDF900);

        // Overflow over three beats; also non-last beat turnaround
        send_beat(16'hFFFF, 16'hFFFF, 16'd0, 1'b0);
        n = 0;
        while (!in_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_eq("beat_turnaround", n, 18);
        send_beat(16'hFFFF, 16'hFFFF, 16'd0, 1'b0);
        send_beat(16'hFFFF, 16'hFFFF, 16'd0, 1'b1);
        recv_frame(2, d, o);
`ifdef APPROX_MAC_SAT_EN
        check_eq("ovf3_data", {31'd0, d}, 64'h1FFFFFFFF);
`else
        check_eq("ovf3_data", {31'd0, d}, 64'h0FFF9EB00);
`endif
        check_eq("ovf3_flag", {63'd0, o}, 64'd1);

        // Backpressure with the next beat already waiting
        send_beat(16'h1234, 16'h5678, 16'h0042, 1'b1);
        in_a     = 16'h0300;
        in_b     = 16'h0011;
        in_c     = 16'h0999;
        in_last  = 1'b1;
        in_valid = 1'b1;
        recv_frame(10, d, o);
        send_beat(16'h0300, 16'h0011, 16'h0999, 1'b1);
        recv_frame(0, d, o);
        check_eq("fresh_bias", {31'd0, d}, 64'h0999 + 64'h3300);

        // Reset in the middle of the second beat's multiply
        send_beat(16'hABCD, 16'h1357, 16'h0055, 1'b0);
        send_beat(16'h2468, 16'hFEDC, 16'h0000, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("mid_rst_out_data", {31'd0, out_data}, 64'd0);
        check_eq("mid_rst_out_ovf", {63'd0, out_ovf}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(16'd2, 16'h0080, 16'd1, 1'b1);
        recv_frame(0, d, o);
        check_eq("post_rst_frame", {31'd0, d}, 64'h101);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
                rc = W'($urandom);
                send_beat(ra, rb, rc, (k == nb - 1));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            recv_frame($urandom_range(0, 3), d, o);
        end

        check_eq("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_mac_seq.md
# approx_mac_seq

Sequential, parametrised successor to the team's combinational 16-bit approximate MAC. Operands are accepted over a valid/ready stream and multiplied with a bit-serial shift-add engine. In each partial product, the columns below `APPROX` are truncated. Products are accumulated across a frame, starting from a bias, and the frame result is emitted on a second valid/ready stream. The block sits between the operand-fetch logic and the result sink in the approximate-arithmetic datapath.

## Interface
Parameters:
- `WIDTH`, 16: operand width, unsigned.
- `APPROX`, 8: number of low product columns truncated per partial product. 0 means exact. Legal range is 0..2·WIDTH−1.
- `ACC_WIDTH`, 40: accumulator and result width. Must be ≥ 2·WIDTH.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low. The block has one clock.
- `in_valid` in 1: an operand beat is present.
- `in_ready` out 1: the block can accept a beat.
- `in_a` in WIDTH: multiplicand.
- `in_b` in WIDTH: multiplier.
- `in_c` in WIDTH: bias. Used only on the first beat of a frame.
- `in_last` in 1: this beat closes the frame.
- `out_valid` out 1: a frame result is present.
- `out_ready` in 1: the sink accepts the result.
- `out_data` out ACC_WIDTH: frame result.
- `out_ovf` out 1: the frame's accumulation exceeded ACC_WIDTH bits.

## Operation
- All arithmetic is unsigned.
- Approximate product: P = Σ_{i=0}^{WIDTH−1} b[i] · ((a << i) & ~(2^APPROX − 1)), computed at 2·WIDTH bits.
- States:
  - IDLE: `in_ready`=1. On an in handshake, latch a, b and last; clear the product register; clear the counter; go to MUL.
  - MUL: one partial product per cycle, LSB of b first. The counter runs 0..WIDTH−1. After the cycle with counter = WIDTH−1, go to ACC.
  - ACC:
    - If the frame is not yet open: acc ← zext(c) + P, and the frame becomes open.
    - If the frame is open: acc ← acc + P.
    - Overflow (carry out of ACC_WIDTH) sets the sticky ovf flag.
    - Next state is OUT if last is set, otherwise IDLE.
  - OUT: `out_valid`=1, with `out_data`=acc and `out_ovf`=ovf. On an out handshake, clear acc, ovf and the frame-open flag, then go to IDLE.
- `in_ready` is 0 in MUL, ACC and OUT. Beats presented during those states wait; they are not dropped.
- `out_data` and `out_ovf` are stable while `out_valid`=1 and `out_ready`=0.
- Reset (including mid-frame or in OUT): state IDLE, acc=0, ovf=0, frame-open=0, counter=0, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_ovf`=0. Any in-flight beat is discarded.

## Timing
- Beat accepted at edge t: MUL occupies t+1..t+WIDTH, ACC is at t+WIDTH+1.
  - Non-last beat: `in_ready` is high again at t+WIDTH+2.
  - Last beat: `out_valid` goes high at t+WIDTH+2.
- Throughput is one beat per WIDTH+2 cycles.
- After an out handshake at edge u, `in_ready`=1 from u+1.
- `in_ready` and `out_valid` are never asserted together.
- There are no combinational paths from inputs to outputs. All outputs are registered or decoded from the state register.

## Configuration
- `APPROX_MAC_SAT_EN` defined: on overflow in ACC, acc is set to 2^ACC_WIDTH−1 and stays saturated for the rest of the frame. ovf is set.
- `APPROX_MAC_SAT_EN` undefined: acc wraps modulo 2^ACC_WIDTH. ovf is set identically.

## Structure
- Package `approx_mac_pkg` holds:
  - the state enum (IDLE, MUL, ACC, OUT);
  - the truncation-mask helper function (WIDTH/APPROX → mask).
- One sub-module, `approx_shift_mul`: a shift-add engine with start/done that owns the counter, the product register and the column mask.
- The top level owns the handshakes, the accumulator, the overflow flag and the frame-open flag.

## Test plan
All scenarios use default parameters unless stated.
- **Full truncation:** single beat a=3, b=5, c=0, last=1 → `out_data`=0, ovf=0. `out_valid` rises 18 cycles after the accept edge.
- **Exact partial product:** a=0x100, b=0x100, c=7, last=1 → `out_data`=0x10007.
- **Maximum operands:** a=b=0xFFFF, c=0, last=1 → `out_data`=0xFFFDF900. With APPROX=0 → 0xFFFE0001.
- **Overflow, ACC_WIDTH=33:** three beats of a=b=0xFFFF, last on the third.
  - With the macro: `out_data`=0x1FFFFFFFF, ovf=1.
  - Without the macro: `out_data`=0x0FFF9EB00, ovf=1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles with `in_valid`=1 → `in_ready` stays 0 and `out_data` stays stable. Release `out_ready` → next frame starts from a fresh bias.
- **Mid-operation reset:** assert `rst_n`=0 mid-MUL of a frame's second beat → next cycle all outputs are 0 and `in_ready`=1. A following single-beat frame a=2, b=0x80, c=1 gives `out_data`=0x101.
